// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Register offsets and default window base for the MMIO I/O hub.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_ADDR = 32'd4096;

    typedef enum logic [1:0] {
        OFS_SW        = 2'd0,
        OFS_LED       = 2'd1,
        OFS_BTN_LEVEL = 2'd2,
        OFS_BTN_EVENT = 2'd3
    } mmio_ofs_e;

endpackage
`default_nettype wire

// File: rtl/mmio_io_hub_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_hub_if
// Purpose  : Processor data-port view of the MMIO window (no handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_io_hub_if;
    import mmio_pkg::*;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, output wdata, output wren, input rdata, input hit);
    modport slave  (input addr, input wdata, input wren, output rdata, output hit);

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser plus stable-count debouncer for one button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic btn_raw,
    output logic      level,
    output logic      rise
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_flip;

    assign w_differ = (r_s2 != r_level);
    assign w_flip   = w_differ && (r_cnt == c_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (r_cnt < c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Rise is combinational so the event register sets on the same edge as the level.
    assign level = r_level;
    assign rise  = w_flip & ~r_level;

endmodule
`default_nettype wire

// File: rtl/mmio_io_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_hub
// Purpose  : Four-register MMIO window for switches, LEDs and debounced buttons.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_hub
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = MMIO_BASE_ADDR,
    parameter int          SW_WIDTH        = 16,
    parameter int          BTN_COUNT       = 4,
    parameter int          LED_WIDTH       = 16,
    parameter int          DEBOUNCE_CYCLES = 400000
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    mmio_io_hub_if.slave              bus,
    input  wire logic [SW_WIDTH-1:0]  sw_in,
    input  wire logic [BTN_COUNT-1:0] btn_in,
    output logic      [LED_WIDTH-1:0] led_out
);

    logic [31:0]          w_offset;
    logic                 w_hit;
    mmio_ofs_e            w_ofs;
    logic                 w_store_led;
    logic [BTN_COUNT-1:0] w_evt_clr;
    logic [BTN_COUNT-1:0] w_btn_level;
    logic [BTN_COUNT-1:0] w_btn_rise;
    logic [31:0]          w_rdata;
    logic                 w_unused_wdata;

    logic [LED_WIDTH-1:0] r_led;
    logic [SW_WIDTH-1:0]  r_sw_s1;
    logic [SW_WIDTH-1:0]  r_sw_s2;
    logic [BTN_COUNT-1:0] r_event;

    // Unsigned subtract makes the window compare immune to addresses below the base.
    assign w_offset    = bus.addr - BASE_ADDR;
    assign w_hit       = (w_offset[31:2] == 30'd0);
    assign w_ofs       = mmio_ofs_e'(w_offset[1:0]);
    assign w_store_led = bus.wren && w_hit && (w_ofs == OFS_LED);
    assign w_evt_clr   = (bus.wren && w_hit && (w_ofs == OFS_BTN_EVENT))
                         ? bus.wdata[BTN_COUNT-1:0] : '0;
    assign w_unused_wdata = ^bus.wdata;

    generate
        for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clock   (clock),
                .reset   (reset),
                .btn_raw (btn_in[gi]),
                .level   (w_btn_level[gi]),
                .rise    (w_btn_rise[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_led   <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_event <= '0;
        end else begin
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
            if (w_store_led) begin
                r_led <= bus.wdata[LED_WIDTH-1:0];
            end
            // A new press beats a coincident clear of the same bit.
            r_event <= (r_event & ~w_evt_clr) | w_btn_rise;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_ofs)
                OFS_SW:        w_rdata[SW_WIDTH-1:0]  = r_sw_s2;
                OFS_LED:       w_rdata[LED_WIDTH-1:0] = r_led;
                OFS_BTN_LEVEL: w_rdata[BTN_COUNT-1:0] = w_btn_level;
                OFS_BTN_EVENT: w_rdata[BTN_COUNT-1:0] = r_event;
                default:       w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.hit   = w_hit;
    assign led_out   = r_led;

endmodule
`default_nettype wire

// File: doc/mmio_io_hub.md
# mmio_io_hub

Memory-mapped I/O controller that sits between the processor's data-memory port and the board's switches, push-buttons and LEDs. It replaces the fixed two-address switch/LED decode with a parametrised register window. The window provides synchronised switch reads and a read-back LED register. It also provides debounced button levels and sticky, write-1-to-clear button press events. The top level muxes `rdata` onto the processor's load path whenever `hit` is high.

## Interface
Parameters:
- `BASE_ADDR`, 4096: word address of register 0; the window spans `BASE_ADDR`..`BASE_ADDR+3`.
- `SW_WIDTH`, 16: number of switch inputs (1–32).
- `BTN_COUNT`, 4: number of push-buttons (1–32).
- `LED_WIDTH`, 16: number of LED outputs (1–32).
- `DEBOUNCE_CYCLES`, 400000: number of stable cycles required before a button level changes (10 ms at 40 MHz); must be ≥ 2.

Ports:
- `clock`, in, 1: single system clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-low; sampled on the `clock` rising edge.
- `addr`, in, 32: processor data address, full-width compare.
- `wdata`, in, 32: store data.
- `wren`, in, 1: store strobe.
- `rdata`, out, 32: read data, combinational from `addr` and registered state; zero when `hit`=0.
- `hit`, out, 1: combinational; high when `addr` falls inside the window.
- `sw_in`, in, `SW_WIDTH`: raw asynchronous switches.
- `btn_in`, in, `BTN_COUNT`: raw asynchronous buttons, active-high.
- `led_out`, out, `LED_WIDTH`: registered LED drive.

## Operation
Register map (offset from `BASE_ADDR`); unused upper bits read as 0:
- +0 SW, read-only: two-flop synchronised `sw_in`. Writes are ignored.
- +1 LED, read/write: a write loads `wdata[LED_WIDTH-1:0]`. A read returns the current `led_out`.
- +2 BTN_LEVEL, read-only: debounced button levels.
- +3 BTN_EVENT, read / write-1-to-clear: bit set on each debounced 0→1 transition of the button. A write with `wdata[i]`=1 clears bit i; `wdata[i]`=0 leaves bit i unchanged.

Behaviour:
- A store outside the window has no effect. A store to a read-only register has no effect.
- Debounce, per button:
  - Two-flop synchroniser, then a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While the synchronised value equals the debounced level, the counter holds 0.
  - While it differs, the counter increments every cycle.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, the level flips on the next edge and the counter returns to 0.
  - Any single cycle of agreement resets the counter to 0, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
  - The counter saturates; it never wraps.
- Event set and W1C clear on the same bit in the same cycle: set wins, and the bit stays 1.
- Reset (synchronous, `reset`=0):
  - `led_out`=0 and all synchroniser flops are 0.
  - Debounced levels=0, counters=0, BTN_EVENT=0.
  - A button held high through reset produces one event `DEBOUNCE_CYCLES` after release of reset plus synchroniser delay, not before.
  - Reset asserted mid-debounce discards the partial count.
  - Reset has priority over a coincident store.

## Timing
- SW: a `sw_in` change is visible in `rdata` after the 2nd rising edge.
- LED: a store on edge N drives `led_out` and read-back from just after edge N (1-cycle write latency).
- Button: a stable raw change appears in BTN_LEVEL after 2 synchroniser edges plus `DEBOUNCE_CYCLES` edges. The BTN_EVENT bit sets on the same edge as the level update.
- `hit`/`rdata` have zero latency; no handshake and no stall. The block must meet timing at 40 MHz.

## Structure
- Package `mmio_pkg` holds the offset constants `OFS_SW`=0, `OFS_LED`=1, `OFS_BTN_LEVEL`=2, `OFS_BTN_EVENT`=3, and the default `BASE_ADDR`. The processor-side decode imports the same package.
- Sub-module `btn_debounce`, instantiated `BTN_COUNT` times via generate. It contains the synchroniser, counter and level register, and outputs `level` plus a one-cycle `rise` pulse.
- The top-level block contains address decode, the LED register, the SW synchroniser, the event register and the read mux.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4 and defaults otherwise.
- Reset and LED: hold `reset`=0 for 3 cycles → `led_out`=0, all reads 0. Store 0xA5A5 to 4097 → `led_out`=0xA5A5 next cycle; read 4097 returns 0x0000A5A5. Store 0xFFFF to 4096 → no change anywhere.
- Switch sync: set `sw_in`=0x1234 → read 4096 returns 0 after 1 edge and 0x1234 after 2 edges.
- Debounce: raise `btn_in[0]` high for 3 cycles then drop it → BTN_LEVEL stays 0 and BTN_EVENT stays 0. Hold it high → BTN_LEVEL=0x1 and BTN_EVENT=0x1 exactly 6 edges after the rise.
- W1C: with BTN_EVENT=0x5, store 0x4 to 4099 → reads 0x1. Store 0x0 → still 0x1.
- Set/clear collision: store 0x2 to 4099 on the same edge `btn_debounce[1]` pulses `rise` → BTN_EVENT bit 1 remains 1.
- Reset mid-debounce: `btn_in[2]` high, assert `reset` after 3 stable cycles, release → level rises only 6 edges after release; `hit`=0 and `rdata`=0 for `addr`=4100.
